// File: rtl/sprite_attr_scanner.sv
// Per-scanline sprite attribute scanner: walks the sprite attribute RAM on each
// line_start and hands every sprite that covers the line to the renderer.
module sprite_attr_scanner #(
    parameter int NUM_SPRITES  = 128,
    parameter int MAX_PER_LINE = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        line_start_i,
    input  logic [9:0]  line_idx_i,
    output logic        rd_en_o,
    output logic [7:0]  rd_addr_o,
    input  logic [31:0] rd_data_i,
    output logic        spr_valid_o,
    input  logic        spr_ready_i,
    output logic [6:0]  spr_idx_o,
    output logic [11:0] spr_addr_o,
    output logic        spr_mode_o,
    output logic [9:0]  spr_x_o,
    output logic [5:0]  spr_row_o,
    output logic        spr_hflip_o,
    output logic [1:0]  spr_z_o,
    output logic [3:0]  spr_coll_o,
    output logic [3:0]  spr_pal_o,
    output logic [1:0]  spr_wcode_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        overflow_o
);

    typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, EVAL, EMIT} state_t;

    localparam logic [6:0] LAST_IDX = 7'(NUM_SPRITES - 1);
    localparam logic [6:0] MAX_CNT  = 7'(MAX_PER_LINE);

    state_t      state, state_n;
    logic [6:0]  index, count, count_inc, fetch_idx;
    logic [9:0]  line_q;
    logic [11:0] w0_addr;
    logic        w0_mode;
    logic [9:0]  w0_x;
    logic [9:0]  height, diff, row_full;
    logic        visible, accept, advance, finish, limit_hit;
    logic        unused_bits;

    assign unused_bits = ^{rd_data_i[14:12], row_full[9:6]};

    // Y-range test on word1; the subtraction wraps at 1024 so sprites straddling
    // the bottom of the coordinate space show up again at the top.
    always_comb begin
        height   = 10'd8 << rd_data_i[31:30];
        diff     = line_q - rd_data_i[9:0];
        visible  = (rd_data_i[19:18] != 2'd0) && (diff < height);
        row_full = rd_data_i[17] ? (height - 10'd1 - diff) : diff;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        advance = 1'b0;
        if (line_start_i) begin
            state_n = FETCH0;
        end else begin
            case (state)
                IDLE:    state_n = IDLE;
                FETCH0:  state_n = FETCH1;
                FETCH1:  state_n = EVAL;
                EVAL:    if (visible) state_n = EMIT; else advance = 1'b1;
                EMIT: begin
                    if (spr_ready_i) begin
                        accept  = 1'b1;
                        advance = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        count_inc = count + {6'd0, accept};
        // Running off the end of the table takes precedence over the limit.
        finish    = (index == LAST_IDX) || (count_inc == MAX_CNT);
        limit_hit = (index != LAST_IDX) && (count_inc == MAX_CNT);
        if (advance) state_n = finish ? IDLE : FETCH0;
        fetch_idx = line_start_i ? 7'd0 : index + 7'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            index       <= 7'd0;
            count       <= 7'd0;
            line_q      <= 10'd0;
            w0_addr     <= 12'd0;
            w0_mode     <= 1'b0;
            w0_x        <= 10'd0;
            rd_en_o     <= 1'b0;
            rd_addr_o   <= 8'd0;
            spr_valid_o <= 1'b0;
            spr_idx_o   <= 7'd0;
            spr_addr_o  <= 12'd0;
            spr_mode_o  <= 1'b0;
            spr_x_o     <= 10'd0;
            spr_row_o   <= 6'd0;
            spr_hflip_o <= 1'b0;
            spr_z_o     <= 2'd0;
            spr_coll_o  <= 4'd0;
            spr_pal_o   <= 4'd0;
            spr_wcode_o <= 2'd0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            state   <= state_n;
            busy_o  <= (state_n != IDLE);
            done_o  <= advance && finish;
            rd_en_o <= (state_n == FETCH0) || (state_n == FETCH1);
            if (state_n == FETCH0)
                rd_addr_o <= {fetch_idx, 1'b0};
            else if (state_n == FETCH1)
                rd_addr_o <= {index, 1'b1};

            if (line_start_i) begin
                line_q      <= line_idx_i;
                index       <= 7'd0;
                count       <= 7'd0;
                overflow_o  <= 1'b0;
                spr_valid_o <= 1'b0;
            end else begin
                if (state == FETCH1) begin
                    w0_addr <= rd_data_i[11:0];
                    w0_mode <= rd_data_i[15];
                    w0_x    <= rd_data_i[25:16];
                end
                if (state == EVAL && visible) begin
                    spr_valid_o <= 1'b1;
                    spr_idx_o   <= index;
                    spr_addr_o  <= w0_addr;
                    spr_mode_o  <= w0_mode;
                    spr_x_o     <= w0_x;
                    spr_row_o   <= row_full[5:0];
                    spr_hflip_o <= rd_data_i[16];
                    spr_z_o     <= rd_data_i[19:18];
                    spr_coll_o  <= rd_data_i[23:20];
                    spr_pal_o   <= rd_data_i[27:24];
                    spr_wcode_o <= rd_data_i[29:28];
                end
                if (accept) begin
                    spr_valid_o <= 1'b0;
                    count       <= count_inc;
                end
                if (advance) begin
                    if (finish)
                        overflow_o <= limit_hit;
                    else
                        index <= index + 7'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_attr_scanner.sv
// Bench for sprite_attr_scanner: a RAM model plus a per-line list model of the
// sprites that must be emitted, checked record by record on every handshake.
module tb_sprite_attr_scanner;

    localparam int NUM  = 128;
    localparam int MAXL = 64;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        line_start_i = 1'b0;
    logic [9:0]  line_idx_i = 10'd0;
    logic        rd_en_o;
    logic [7:0]  rd_addr_o;
    logic [31:0] rd_data_i = 32'd0;
    logic        spr_valid_o;
    logic        spr_ready_i = 1'b1;
    logic [6:0]  spr_idx_o;
    logic [11:0] spr_addr_o;
    logic        spr_mode_o;
    logic [9:0]  spr_x_o;
    logic [5:0]  spr_row_o;
    logic        spr_hflip_o;
    logic [1:0]  spr_z_o;
    logic [3:0]  spr_coll_o;
    logic [3:0]  spr_pal_o;
    logic [1:0]  spr_wcode_o;
    logic        busy_o;
    logic        done_o;
    logic        overflow_o;

    always #5 clk = ~clk;

    sprite_attr_scanner #(.NUM_SPRITES(NUM), .MAX_PER_LINE(MAXL)) dut (
        .clk_i(clk), .rst_i(rst_i), .line_start_i(line_start_i), .line_idx_i(line_idx_i),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .spr_valid_o(spr_valid_o), .spr_ready_i(spr_ready_i), .spr_idx_o(spr_idx_o),
        .spr_addr_o(spr_addr_o), .spr_mode_o(spr_mode_o), .spr_x_o(spr_x_o),
        .spr_row_o(spr_row_o), .spr_hflip_o(spr_hflip_o), .spr_z_o(spr_z_o),
        .spr_coll_o(spr_coll_o), .spr_pal_o(spr_pal_o), .spr_wcode_o(spr_wcode_o),
        .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
    );

    // Record layout: idx[48:42] addr[41:30] mode[29] x[28:19] row[18:13]
    // hflip[12] z[11:10] coll[9:6] pal[5:2] wcode[1:0]
    logic [48:0] dut_rec;
    logic [61:0] all_outs;
    assign dut_rec  = {spr_idx_o, spr_addr_o, spr_mode_o, spr_x_o, spr_row_o,
                       spr_hflip_o, spr_z_o, spr_coll_o, spr_pal_o, spr_wcode_o};
    assign all_outs = {rd_en_o, rd_addr_o, spr_valid_o, dut_rec, busy_o, done_o, overflow_o};

    logic [31:0] mem [0:255];
    always @(posedge clk) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

    int n_cmp = 0;
    int n_err = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failNote(input string name);
        n_cmp++;
        n_err++;
        $display("[TB] FAIL %s: condition not met", name);
    endtask

    logic [48:0] exp_q[$];
    logic        exp_ovf = 1'b0;
    int          exp_total = 0;
    int          acc_line = 0;
    logic [48:0] last_rec = '0;
    bit          active = 1'b0;
    bit          prev_stall = 1'b0;
    logic [48:0] prev_rec = '0;

    // The list of records a line must produce, straight from the sprite table.
    function automatic void build_model(input logic [9:0] line);
        exp_q.delete();
        exp_ovf = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            logic [31:0] w0, w1;
            int h, y, diff, row;
            w0   = mem[2*i];
            w1   = mem[2*i+1];
            h    = 8 << int'(w1[31:30]);
            y    = int'(w1[9:0]);
            diff = (int'(line) - y + 1024) % 1024;
            if (w1[19:18] != 2'd0 && diff < h) begin
                row = w1[17] ? (h - 1 - diff) : diff;
                exp_q.push_back({7'(i), w0[11:0], w0[15], w0[25:16], 6'(row),
                                 w1[16], w1[19:18], w1[23:20], w1[27:24], w1[29:28]});
                if (exp_q.size() == MAXL && i != NUM - 1) begin
                    exp_ovf = 1'b1;
                    break;
                end
            end
        end
        exp_total = exp_q.size();
    endfunction

    always @(negedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            active     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                checkOutput("stall_hold", 64'({spr_valid_o, dut_rec}), 64'({1'b1, prev_rec}));
            if (spr_valid_o)
                checkOutput("no_rd_in_emit", 64'(rd_en_o), 64'(0));
            if (spr_valid_o && spr_ready_i) begin
                if (!active || exp_q.size() == 0) begin
                    failNote("unexpected_record");
                end else begin
                    checkOutput("record", 64'(dut_rec), 64'(exp_q.pop_front()));
                end
                acc_line++;
                last_rec = dut_rec;
            end
            if (done_o) begin
                if (!active) begin
                    failNote("spurious_done");
                end else begin
                    checkOutput("missing_records", 64'(exp_q.size()), 64'(0));
                    checkOutput("overflow_at_done", 64'(overflow_o), 64'(exp_ovf));
                end
                active = 1'b0;
            end
            if (line_start_i) begin
                build_model(line_idx_i);
                active   = 1'b1;
                acc_line = 0;
            end
            prev_stall = spr_valid_o && !spr_ready_i && !line_start_i;
            prev_rec   = dut_rec;
        end
    end

    // Ready driver: 0 = always ready, 1 = random, 2 = hold off 10 cycles per record.
    int ready_mode = 0;
    initial begin
        int stall_cnt;
        stall_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: spr_ready_i = 1'b1;
                1: spr_ready_i = 1'($urandom_range(0, 1));
                default: begin
                    spr_ready_i = spr_valid_o && (stall_cnt >= 10);
                    stall_cnt   = spr_valid_o ? stall_cnt + 1 : 0;
                end
            endcase
        end
    end

    task automatic applyStimulus(input logic [9:0] line);
        @(posedge clk);
        #1;
        line_idx_i   = line;
        line_start_i = 1'b1;
        @(posedge clk);
        #1;
        line_start_i = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int cycles);
        bit got;
        got    = 1'b0;
        cycles = 0;
        while (cycles < budget && !got) begin
            @(negedge clk);
            cycles++;
            if (done_o) got = 1'b1;
        end
        if (!got) failNote("done_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    initial begin
        int cyc;
        logic [9:0] line;
        clearMem();
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", 64'(all_outs), 64'(0));
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_outputs", 64'(all_outs), 64'(0));

        $display("[TB] single sprite, plain and flipped");
        for (int i = 0; i < NUM; i++) mem[2*i] = $urandom;
        mem[11] = {2'b01, 2'b10, 4'h5, 4'h9, 2'b01, 1'b0, 1'b1, 6'd0, 10'd100};
        applyStimulus(10'd107);
        waitDone(1000, cyc);
        checkOutput("done_latency", 64'(cyc - 1), 64'(3*NUM + 1));
        checkOutput("t1_model_count", 64'(exp_total), 64'(1));
        checkOutput("t1_rec_count", 64'(acc_line), 64'(1));
        checkOutput("t1_idx", 64'(last_rec[48:42]), 64'(5));
        checkOutput("t1_row", 64'(last_rec[18:13]), 64'(7));
        checkOutput("t1_busy_idle", 64'(busy_o), 64'(0));

        mem[11][17] = 1'b1;
        applyStimulus(10'd107);
        waitDone(1000, cyc);
        checkOutput("vflip_rec_count", 64'(acc_line), 64'(1));
        checkOutput("vflip_row", 64'(last_rec[18:13]), 64'(8));

        applyStimulus(10'd116);
        waitDone(1000, cyc);
        checkOutput("below_sprite_none", 64'(acc_line), 64'(0));
        applyStimulus(10'd99);
        waitDone(1000, cyc);
        checkOutput("above_sprite_none", 64'(acc_line), 64'(0));

        $display("[TB] Y wrap-around");
        mem[11] = {2'b00, 2'b00, 4'h0, 4'h0, 2'b10, 1'b0, 1'b0, 6'd0, 10'd1020};
        applyStimulus(10'd3);
        waitDone(1000, cyc);
        checkOutput("wrap_rec_count", 64'(acc_line), 64'(1));
        checkOutput("wrap_row", 64'(last_rec[18:13]), 64'(7));

        $display("[TB] stalled renderer");
        clearMem();
        for (int i = 0; i < 3; i++) begin
            mem[2*i]   = $urandom;
            mem[2*i+1] = $urandom;
            mem[2*i+1][31:30] = 2'd0;
            mem[2*i+1][19:18] = 2'(i + 1);
            mem[2*i+1][9:0]   = 10'd48;
        end
        ready_mode = 2;
        applyStimulus(10'd50);
        waitDone(3000, cyc);
        checkOutput("stall_rec_count", 64'(acc_line), 64'(3));
        checkOutput("stall_last_idx", 64'(last_rec[48:42]), 64'(2));

        $display("[TB] per-line limit");
        ready_mode = 0;
        for (int i = 0; i < NUM; i++) begin
            mem[2*i]   = $urandom;
            mem[2*i+1] = $urandom;
            mem[2*i+1][31:30] = 2'd3;
            mem[2*i+1][19:18] = 2'($urandom_range(1, 3));
            mem[2*i+1][9:0]   = 10'd0;
        end
        applyStimulus(10'd10);
        waitDone(1000, cyc);
        checkOutput("limit_model_count", 64'(exp_total), 64'(64));
        checkOutput("limit_rec_count", 64'(acc_line), 64'(64));
        checkOutput("limit_last_idx", 64'(last_rec[48:42]), 64'(63));
        checkOutput("limit_overflow", 64'(overflow_o), 64'(1));
        applyStimulus(10'd500);
        checkOutput("overflow_cleared", 64'(overflow_o), 64'(0));
        waitDone(1000, cyc);
        checkOutput("empty_line_count", 64'(acc_line), 64'(0));

        $display("[TB] restart during a record");
        clearMem();
        for (int i = 0; i < 6; i++) begin
            mem[2*i]   = $urandom;
            mem[2*i+1] = $urandom;
            mem[2*i+1][31:30] = 2'd1;
            mem[2*i+1][19:18] = 2'd3;
            mem[2*i+1][9:0]   = 10'd200;
        end
        ready_mode = 2;
        applyStimulus(10'd205);
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 500 && !seen; c++) begin
                @(posedge clk);
                #1;
                if (spr_valid_o && spr_idx_o == 7'd3) seen = 1'b1;
            end
            if (!seen) failNote("abort_wait_sprite3");
        end
        applyStimulus(10'd210);
        checkOutput("abort_valid_dropped", 64'(spr_valid_o), 64'(0));
        checkOutput("abort_fetch_addr0", 64'({rd_en_o, rd_addr_o}), 64'({1'b1, 8'd0}));
        waitDone(3000, cyc);
        checkOutput("abort_new_line_count", 64'(acc_line), 64'(6));

        $display("[TB] randomized lines");
        ready_mode = 1;
        for (int t = 0; t < 4; t++) begin
            line = 10'($urandom_range(0, 1023));
            for (int i = 0; i < NUM; i++) begin
                mem[2*i]   = $urandom;
                mem[2*i+1] = $urandom;
                mem[2*i+1][9:0] = line - 10'($urandom_range(0, 90));
            end
            applyStimulus(line);
            waitDone(6000, cyc);
        end

        $display("[TB] reset mid-scan");
        ready_mode = 0;
        for (int i = 0; i < NUM; i++) begin
            mem[2*i+1][31:30] = 2'd3;
            mem[2*i+1][19:18] = 2'd1;
            mem[2*i+1][9:0]   = 10'd0;
        end
        applyStimulus(10'd20);
        repeat (21) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_midscan", 64'(all_outs), 64'(0));
        rst_i = 1'b0;
        applyStimulus(10'd20);
        waitDone(1000, cyc);
        checkOutput("after_reset_count", 64'(acc_line), 64'(64));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
